gray_conv_sched: RTL and testbench

Round-robin scheduler that shares a single bit-serial Gray-to-binary conversion engine between `1<<IDW` requesters. Each requester presents a `W`-bit Gray code with a valid/ready handshake. The block grants one requester at a time and converts the code MSB-first, one bit per clock. It returns the binary result, tagged with the requester ID, on a valid/ready response port. It sits between the per-channel position/counter sources and the consumers that need binary values.

---
 rtl/gray_conv_sched.sv | 118 +++++++++++
 tb/tb_gray_conv_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one bit-serial Gray-to-binary engine among 1<<IDW requesters.
// A granted code is converted MSB-first, one bit per clock, and returned with its requester ID.
module gray_conv_sched #(
    parameter int W   = 3,
    parameter int IDW = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(1<<IDW)-1:0]       req_valid,
    input  logic [(1<<IDW)*W-1:0]     req_gray,
    output logic [(1<<IDW)-1:0]       req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [W-1:0]              rsp_bin,
    output logic                      busy
);
    localparam int N  = 1 << IDW;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_bin;
    logic [W-1:0]   r_sr;
    logic [IW-1:0]  r_idx;
    logic           r_prev;
    logic           r_valid;

    logic           w_found;
    logic [IDW-1:0] w_gnt;
    logic [IDW-1:0] w_cand;
    logic           w_accept;
    logic           w_bit;
    logic [W-1:0]   w_gray_sel;

    // Search starts one past the last grant; the IDW-bit add wraps modulo N.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = r_last + IDW'(k);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_gray_sel = req_gray[w_gnt*W +: W];
    assign req_ready  = (w_accept && rst_n) ? (N'(1) << w_gnt) : '0;

    // Each binary bit is the previous (higher) binary bit XOR the current Gray bit.
    assign w_bit = r_sr[W-1] ^ r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= IDW'(N - 1);
            r_id    <= '0;
            r_bin   <= '0;
            r_idx   <= '0;
            r_prev  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_gnt;
                        r_last  <= w_gnt;
                        r_idx   <= IW'(W - 1);
                        r_bin   <= '0;
                        r_prev  <= 1'b0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bin[r_idx] <= w_bit;
                    r_prev       <= w_bit;
                    if (r_idx == '0) begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shift register holds payload only; its contents are irrelevant until the next accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sr <= w_gray_sel;
        end else if (r_state == S_CONV) begin
            r_sr <= r_sr << 1;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_id    = r_id;
    assign rsp_bin   = r_bin;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gray_conv_sched.sv
// Scoreboard bench for gray_conv_sched: queued per-requester sources, a round-robin/Gray
// reference model, and a negedge monitor that checks grants, timing and results.
module tb_gray_conv_sched;
    localparam int W   = 3;
    localparam int IDW = 2;
    localparam int N   = 1 << IDW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_gray = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_bin;
    logic             busy;

    gray_conv_sched #(.W(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_bin(rsp_bin), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   bin;
    } exp_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    exp_t         sb_q[$];
    logic [W-1:0] src_q[N][$];
    int           obs_id[$];
    int           obs_bin[$];

    logic [N-1:0] acc_mask = '0;
    bit  gap_en = 0;
    int  rr_mode = 0;
    bit  mon_en = 0;
    bit  m_busy = 0;
    int  m_last = N - 1;
    int  cyc = 0;
    int  acc_cyc = 0;
    int  rdy0_cnt = 0;
    bit  prev_hold = 0;
    logic [IDW-1:0] prev_id;
    logic [W-1:0]   prev_bin;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Binary value = XOR of all right-shifts of the Gray code.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 0;
        return 1;
    endfunction

    // Driver: presents queued codes, retires accepted ones, drives rsp_ready.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                req_valid[i] = 1'b0;
            end
        end
        acc_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                req_valid[i] = 1'b1;
                req_gray[i*W +: W] = src_q[i][0];
            end
        end
        case (rr_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: all expectations come from the model state (m_busy, m_last, sb_q).
    always @(negedge clk) begin
        if (mon_en) begin
            bit was_busy;
            int g;
            logic [N-1:0] exp_rdy;
            exp_t e;
            cyc++;
            was_busy = m_busy;
            g = was_busy ? -1 : rr_pick(req_valid, m_last);
            exp_rdy = (g < 0) ? '0 : (N'(1) << g);
            if (req_ready[0]) rdy0_cnt++;
            chk("busy", busy, was_busy);
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, was_busy && (cyc >= acc_cyc + W + 1));
            if (was_busy && rsp_valid) begin
                if (prev_hold) begin
                    chk("hold_id", rsp_id, prev_id);
                    chk("hold_bin", rsp_bin, prev_bin);
                end
                if (rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_bin", rsp_bin, e.bin);
                    end
                    obs_id.push_back(int'(rsp_id));
                    obs_bin.push_back(int'(rsp_bin));
                    m_busy = 0;
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_id   = rsp_id;
            prev_bin  = rsp_bin;
            if (g >= 0) begin
                e.id  = IDW'(g);
                e.bin = g2b(req_gray[g*W +: W]);
                sb_q.push_back(e);
                m_last = g;
                acc_mask[g] = 1'b1;
                m_busy = 1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((m_busy || sb_q.size() > 0 || !src_empty() || req_valid != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (n < budget), 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] sweep[8];
        sweep = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        // Reset state, with every requester asking.
        req_valid = '1;
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_bin", rsp_bin, 0);
        chk("rst_busy", busy, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        // Single request.
        rdy0_cnt = 0;
        obs_id.delete(); obs_bin.delete();
        src_q[0].push_back(3'b110);
        wait_drain("single_drain", 50);
        chk("single_pulse", rdy0_cnt, 1);
        chk("single_bin", (obs_bin.size() > 0) ? obs_bin[0] : -1, 4);
        chk("single_id", (obs_id.size() > 0) ? obs_id[0] : -1, 0);

        // Full Gray sweep on requester 2.
        obs_id.delete(); obs_bin.delete();
        for (int k = 0; k < 8; k++) src_q[2].push_back(sweep[k]);
        wait_drain("sweep_drain", 200);
        chk("sweep_count", obs_bin.size(), 8);
        for (int k = 0; k < 8 && k < obs_bin.size(); k++) begin
            chk("sweep_bin", obs_bin[k], k);
            chk("sweep_id", obs_id[k], 2);
        end

        // All four requesters valid together; last grant was 2.
        obs_id.delete(); obs_bin.delete();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) src_q[i].push_back(W'($urandom));
        wait_drain("all_drain", 300);
        chk("all_count", obs_id.size(), 12);
        for (int k = 0; k < 12 && k < obs_id.size(); k++) chk("all_order", obs_id[k], (3 + k) % N);

        // Fairness between requesters 1 and 3; last grant was 2.
        obs_id.delete(); obs_bin.delete();
        for (int k = 0; k < 4; k++) begin
            src_q[1].push_back(W'($urandom));
            src_q[3].push_back(W'($urandom));
        end
        wait_drain("fair_drain", 200);
        chk("fair_count", obs_id.size(), 8);
        for (int k = 0; k < 8 && k < obs_id.size(); k++) chk("fair_order", obs_id[k], (k % 2 == 0) ? 3 : 1);

        // Back-pressure in DONE.
        rr_mode = 2;
        src_q[1].push_back(3'b101);
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk("bp_reach_done", (n < 40), 1);
        src_q[2].push_back(3'b011);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        rr_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0100);
        wait_drain("bp_drain", 100);

        // Reset during the second CONV cycle.
        src_q[1].push_back(3'b111);
        n = 0;
        while (!req_ready[1] && n < 40) begin @(negedge clk); n++; end
        chk("mid_accept_seen", (n < 40), 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_rsp_bin", rsp_bin, 0);
        chk("mid_busy", busy, 0);
        chk("mid_req_ready", req_ready, 0);
        sb_q.delete();
        m_busy = 0;
        m_last = N - 1;
        prev_hold = 0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        req_valid = '0;
        src_q[3].push_back(3'b010);
        src_q[0].push_back(3'b001);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_valid_seen", req_valid, 4'b1001);
        chk("mid_rst_ready_low", req_ready, 0);
        obs_id.delete(); obs_bin.delete();
        rst_n = 1'b1;
        mon_en = 1;
        wait_drain("mid_drain", 100);
        chk("mid_first", (obs_id.size() > 0) ? obs_id[0] : -1, 0);
        chk("mid_second", (obs_id.size() > 1) ? obs_id[1] : -1, 3);

        // Randomized traffic with gaps and random back-pressure.
        gap_en = 1;
        rr_mode = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (src_q[r].size() < 4) src_q[r].push_back(W'($urandom));
            end
        end
        wait_drain("rand_drain", 3000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
